// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: keypad-driven HH:MM time-setting controller.
// Edge-detects keypad presses, runs IDLE/ENTRY/CONFIRM digit entry with
// per-position range checks, and stages a BCD time. A one-cycle load strobe
// hands the staged time to the timekeeping counters.
// Optional feature macro: KEY_TIMEOUT_EN (inactivity timeout back to IDLE).
module clock_set_ctrl #(
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd10_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] key_value,
    input  logic       key_flag,
    output logic       edit_mode,
    output logic [1:0] digit_pos,
    output logic [7:0] set_hh,
    output logic [7:0] set_mm,
    output logic       load,
    output logic       err
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ENTRY   = 2'd1;
    localparam logic [1:0] ST_CONFIRM = 2'd2;

    localparam logic [3:0] KEY_SET    = 4'd10;
    localparam logic [3:0] KEY_ENTER  = 4'd11;
    localparam logic [3:0] KEY_CANCEL = 4'd12;
    localparam logic [3:0] KEY_BACK   = 4'd13;

    // Range check of a digit for the position it would occupy.
    function automatic logic digit_ok(input logic [1:0] pos,
                                      input logic [3:0] d,
                                      input logic [3:0] h_tens);
        logic ok;
        case (pos)
            2'd0:    ok = (d <= 4'd2);
            2'd1:    ok = (h_tens == 4'd2) ? (d <= 4'd3) : (d <= 4'd9);
            2'd2:    ok = (d <= 4'd5);
            2'd3:    ok = (d <= 4'd9);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    logic       key_flag_d;
    logic       press_r;
    logic [3:0] key_r;
    logic [1:0] state;

    logic [1:0] state_n;
    logic [1:0] pos_n;
    logic [7:0] hh_n;
    logic [7:0] mm_n;
    logic       load_n;
    logic       err_n;
    logic       timeout_hit;
    logic       is_digit;

`ifdef KEY_TIMEOUT_EN
    logic [23:0] idle_cnt;

    // Inactivity counter: runs only while editing, cleared by any accepted press.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idle_cnt <= 24'd0;
        end else if (state == ST_IDLE || press_r || timeout_hit) begin
            idle_cnt <= 24'd0;
        end else begin
            idle_cnt <= idle_cnt + 24'd1;
        end
    end

    assign timeout_hit = (state != ST_IDLE) && (idle_cnt == TIMEOUT_CYCLES - 24'd1);
`else
    assign timeout_hit = 1'b0;
`endif

    assign is_digit = (key_r <= 4'd9);

    // Press detection: capture a rising key_flag and its key code for the FSM.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            key_flag_d <= 1'b0;
            press_r    <= 1'b0;
            key_r      <= 4'd0;
        end else begin
            key_flag_d <= key_flag;
            press_r    <= key_flag & ~key_flag_d;
            key_r      <= key_value;
        end
    end

    // Next-state logic for the entry FSM, staging, and strobes.
    always_comb begin
        state_n = state;
        pos_n   = digit_pos;
        hh_n    = set_hh;
        mm_n    = set_mm;
        load_n  = 1'b0;
        err_n   = 1'b0;
        if (press_r) begin
            case (state)
                ST_IDLE: begin
                    if (key_r == KEY_SET) begin
                        state_n = ST_ENTRY;
                        pos_n   = 2'd0;
                        hh_n    = 8'h00;
                        mm_n    = 8'h00;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end
                ST_ENTRY: begin
                    if (is_digit) begin
                        if (digit_ok(digit_pos, key_r, set_hh[7:4])) begin
                            case (digit_pos)
                                2'd0:    hh_n[7:4] = key_r;
                                2'd1:    hh_n[3:0] = key_r;
                                2'd2:    mm_n[7:4] = key_r;
                                default: mm_n[3:0] = key_r;
                            endcase
                            if (digit_pos == 2'd3) begin
                                state_n = ST_CONFIRM;
                            end else begin
                                pos_n = digit_pos + 2'd1;
                            end
                        end else begin
                            err_n = 1'b1;
                        end
                    end else if (key_r == KEY_BACK) begin
                        // Step back one position and blank the digit landed on.
                        case (digit_pos)
                            2'd1: begin pos_n = 2'd0; hh_n[7:4] = 4'd0; end
                            2'd2: begin pos_n = 2'd1; hh_n[3:0] = 4'd0; end
                            2'd3: begin pos_n = 2'd2; mm_n[7:4] = 4'd0; end
                            default: pos_n = digit_pos;
                        endcase
                    end else if (key_r == KEY_SET) begin
                        pos_n = 2'd0;
                        hh_n  = 8'h00;
                        mm_n  = 8'h00;
                    end else if (key_r == KEY_CANCEL) begin
                        state_n = ST_IDLE;
                    end else begin
                        state_n = ST_ENTRY;
                    end
                end
                ST_CONFIRM: begin
                    if (key_r == KEY_ENTER) begin
                        load_n  = 1'b1;
                        state_n = ST_IDLE;
                    end else if (key_r == KEY_BACK) begin
                        state_n   = ST_ENTRY;
                        pos_n     = 2'd3;
                        mm_n[3:0] = 4'd0;
                    end else if (key_r == KEY_CANCEL) begin
                        state_n = ST_IDLE;
                    end else if (key_r == KEY_SET) begin
                        state_n = ST_ENTRY;
                        pos_n   = 2'd0;
                        hh_n    = 8'h00;
                        mm_n    = 8'h00;
                    end else begin
                        state_n = ST_CONFIRM;
                    end
                end
                default: state_n = ST_IDLE;
            endcase
        end else if (timeout_hit) begin
            state_n = ST_IDLE;
        end else begin
            state_n = state;
        end
    end

    // Register FSM state and every output.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            edit_mode <= 1'b0;
            digit_pos <= 2'd0;
            set_hh    <= 8'h00;
            set_mm    <= 8'h00;
            load      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_n;
            edit_mode <= (state_n != ST_IDLE);
            digit_pos <= pos_n;
            set_hh    <= hh_n;
            set_mm    <= mm_n;
            load      <= load_n;
            err       <= err_n;
        end
    end

endmodule
